vm_coin_acceptor: RTL and testbench
===================================

Name: vm_coin_acceptor

Overview:
- Front-end feeding the money inputs of vending_machine; drives the other end of its money interface.
- Converts raw coin-slot sensor and cancel-button signals into clean one-cycle Ten_bucks / Twenty_bucks / Cancel pulses.
- Debounces the raw inputs and buffers inserted coins in a small FIFO.
- Paces pulses to the machine, which has no acknowledge; rejects coins it cannot buffer.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive equal synchronized samples required to change a debounced level (1..15).
- FIFO_DEPTH, 4: coin buffer entries; power of 2, minimum 2.
- GAP_CYCLES, 2: idle cycles forced after every emitted pulse (1..15).

Ports:
- Clock, in, 1: system clock, rising edge.
- Reset, in, 1: synchronous, active-low reset.
- Coin_sense, in, 1: raw asynchronous coin-present sensor.
- Coin_type, in, 1: raw coin class, 0 = ten, 1 = twenty; stable while Coin_sense is high.
- Cancel_btn, in, 1: raw asynchronous cancel button.
- Hold, in, 1: downstream busy; blocks new emissions.
- Ten_bucks, out, 1: one-cycle pulse, ten credited.
- Twenty_bucks, out, 1: one-cycle pulse, twenty credited.
- Cancel, out, 1: one-cycle pulse, refund request.
- Coin_reject, out, 1: one-cycle pulse, coin dropped and reject gate fired.
- Full, out, 1: FIFO holds FIFO_DEPTH entries.

Behaviour:
- Reset
  - Reset=0 sampled at a rising Clock edge clears all state.
  - Ten_bucks, Twenty_bucks, Cancel, Coin_reject and Full are all 0.
  - FIFO empty, debounced levels 0, cancel_pending 0, FSM in IDLE.
  - Reset mid-pulse or mid-gap aborts it; queued coins are lost.
- Synchronizers
  - Coin_sense, Coin_type and Cancel_btn each pass through 2 flops.
- Debounce (per signal)
  - Counter increments while the synchronized value differs from the debounced level; it clears on any cycle where they are equal.
  - The debounced level flips on the cycle the counter reaches DEBOUNCE_CYCLES; the counter clears at the same time.
- Coin event
  - Occurs on the cycle the debounced Coin_sense goes 0->1.
  - Class = synchronized Coin_type in that cycle.
  - The event pushes the class into the FIFO unless the FIFO is full or cancel_pending=1.
  - In either of those cases the coin is dropped and Coin_reject pulses the next cycle.
- Cancel event
  - Occurs on the cycle the debounced Cancel_btn goes 0->1.
  - Sets cancel_pending. A repeat event while cancel_pending is set is ignored.
- Emitter FSM (registered outputs)
  - IDLE:
    - If Hold=0 and the FIFO is non-empty: pop the head and go to PULSE, with Ten_bucks=1 if head=0, else Twenty_bucks=1.
    - Else if Hold=0, the FIFO is empty and cancel_pending=1: go to PULSE with Cancel=1 and clear cancel_pending.
    - Otherwise stay in IDLE.
  - PULSE: outputs high for exactly 1 cycle, then GAP.
  - GAP: all pulse outputs 0 for GAP_CYCLES cycles, then IDLE. Hold does not affect PULSE or GAP.
- Ordering
  - Coins leave in insertion order.
  - Cancel is emitted only after every coin queued before it has been emitted.
  - At most one of Ten_bucks / Twenty_bucks / Cancel is high in any cycle.
- Latency
  - Raw Coin_sense rise to pulse high = DEBOUNCE_CYCLES+4 cycles.
  - This holds when the FIFO is empty, the FSM is in IDLE, Hold=0 and the signal is bounce-free.
  - Breakdown: 2 sync, DEBOUNCE_CYCLES debounce, 1 push, 1 pop/output register.
- Simultaneous push and pop
  - Allowed in the same cycle; occupancy is unchanged.
  - When full, a pop in the same cycle as a coin event does not free a slot for that event: the coin is rejected.
- Full is a registered output that reflects occupancy == FIFO_DEPTH.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.

Optional Feature:
- Macro: COIN_CREDIT_EN.
- When defined:
  - Adds output Credit_total [7:0], reset 0.
  - Adds 10 on each Ten_bucks pulse and 20 on each Twenty_bucks pulse, updating the cycle after the pulse.
  - Saturates at 250.
  - Clears to 0 the cycle after a Cancel pulse.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Single ten coin: clean Coin_sense high for 10 cycles, Coin_type=0, DEBOUNCE_CYCLES=4 -> Ten_bucks high for 1 cycle exactly 8 cycles after the raw rise; no other pulses.
- Bounce: Coin_sense toggles every 2 cycles for 12 cycles, then stays low -> no pulse, FIFO empty, Coin_reject 0.
- Burst: 6 coins (T,W,W,T,T,W) inserted quickly with Hold=1, FIFO_DEPTH=4 -> Full=1 after the 4th; coins 5 and 6 each give one Coin_reject pulse. After Hold=0: Ten, Twenty, Twenty, Ten, each pulse separated by exactly 2 low cycles.
- Cancel ordering: 2 twenty coins queued, Hold=1, then Cancel_btn pressed, then a third coin -> third coin rejected. After release: Twenty, Twenty, Cancel in that order; cancel_pending cleared.
- Reset mid-operation: Reset=0 for 1 cycle during GAP with 3 coins queued -> all outputs 0 the next cycle, Full=0, and no pulse ever emitted for the lost coins.
- COIN_CREDIT_EN: emit T, W, W -> Credit_total reads 10, 30, 50; 12 more twenty coins -> saturates at 250; Cancel -> 0.

Source files
------------

// File: rtl/vm_coin_acceptor.sv
// vm_coin_acceptor
// Front-end for the vending_machine money interface. Raw coin-slot sensor
// and cancel-button inputs are synchronized and debounced. Each inserted coin
// is buffered in a small FIFO, and the coins are then paced out as clean
// one-cycle pulses. The downstream machine has no acknowledge.
//
// Ports:
//   Clock        : system clock, rising edge
//   Reset        : synchronous, active-low reset
//   Coin_sense   : raw asynchronous coin-present sensor
//   Coin_type    : raw coin class (0 = ten, 1 = twenty), stable while sensed
//   Cancel_btn   : raw asynchronous cancel button
//   Hold         : downstream busy, blocks new emissions
//   Ten_bucks    : one-cycle pulse, ten credited
//   Twenty_bucks : one-cycle pulse, twenty credited
//   Cancel       : one-cycle pulse, refund request
//   Coin_reject  : one-cycle pulse, coin dropped and reject gate fired
//   Full         : coin FIFO holds FIFO_DEPTH entries
//   Credit_total : running credit, saturating at 250 (COIN_CREDIT_EN only)
//
// Optional feature macro: COIN_CREDIT_EN (adds Credit_total).

module vm_coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Coin_sense,
  input  logic       Coin_type,
  input  logic       Cancel_btn,
  input  logic       Hold,
  output logic       Ten_bucks,
  output logic       Twenty_bucks,
  output logic       Cancel,
  output logic       Coin_reject,
  output logic       Full
`ifdef COIN_CREDIT_EN
  ,
  output logic [7:0] Credit_total
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  // Bit 0 = coin sense, bit 1 = cancel button.
  logic [1:0]    raw;
  logic [1:0]    sync_p0, sync_p1;
  logic          type_p0, type_p1;
  logic [1:0]    lvl_p2, lvl_p3;
  logic [3:0]    cnt_p2 [2];

  logic          coin_evt, cancel_evt;
  logic          cancel_pending;

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, occ;
  logic          mem [FIFO_DEPTH];
  logic          fifo_full, fifo_empty, head;
  logic          push, pop;

  state_t        state;
  logic [3:0]    gap_cnt;
  logic          gap_last, may_launch, launch_coin, launch_cancel;

  assign raw = {Cancel_btn, Coin_sense};

  // ---- Stage p0/p1: two-flop synchronizers ----
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      type_p0 <= 1'b0;
      type_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      type_p0 <= Coin_type;
      type_p1 <= type_p0;
    end
  end

  // ---- Stage p2: debounced levels; p3 holds last level for edge detect ----
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      lvl_p2 <= '0;
      lvl_p3 <= '0;
      for (int i = 0; i < 2; i++) cnt_p2[i] <= '0;
    end else begin
      lvl_p3 <= lvl_p2;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == lvl_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == 4'(DEBOUNCE_CYCLES - 1)) begin
          // This sample is the DEBOUNCE_CYCLES-th consecutive differing one.
          lvl_p2[i] <= sync_p1[i];
          cnt_p2[i] <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + 4'd1;
        end
      end
    end
  end

  assign coin_evt   = lvl_p2[0] & ~lvl_p3[0];
  assign cancel_evt = lvl_p2[1] & ~lvl_p3[1];

  // ---- Coin FIFO ----
  assign occ        = wr_ptr - rd_ptr;
  assign fifo_full  = (occ == PW'(FIFO_DEPTH));
  assign fifo_empty = (occ == '0);
  assign head       = mem[rd_ptr[AW-1:0]];

  // Fullness is judged before this cycle's pop, so a simultaneous pop never
  // makes room for the arriving coin.
  assign push       = coin_evt & ~fifo_full & ~cancel_pending;
  assign pop        = launch_coin;
  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      Full           <= 1'b0;
      Coin_reject    <= 1'b0;
      cancel_pending <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 1'b0;
    end else begin
      if (push) mem[wr_ptr[AW-1:0]] <= type_p1;
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      Full        <= ((wr_ptr_nxt - rd_ptr_nxt) == PW'(FIFO_DEPTH));
      Coin_reject <= coin_evt & ~push;
      if (launch_cancel)   cancel_pending <= 1'b0;
      else if (cancel_evt) cancel_pending <= 1'b1;
    end
  end

  // ---- Emitter FSM ----
  // The last GAP cycle makes the IDLE decision directly, so back-to-back
  // pulses are separated by exactly GAP_CYCLES low cycles.
  assign gap_last      = (state == GAP) && (gap_cnt == 4'(GAP_CYCLES - 1));
  assign may_launch    = (state == IDLE) | gap_last;
  assign launch_coin   = may_launch & ~Hold & ~fifo_empty;
  assign launch_cancel = may_launch & ~Hold & fifo_empty & cancel_pending;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      Ten_bucks    <= 1'b0;
      Twenty_bucks <= 1'b0;
      Cancel       <= 1'b0;
    end else begin
      Ten_bucks    <= 1'b0;
      Twenty_bucks <= 1'b0;
      Cancel       <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (launch_coin) begin
            Ten_bucks    <= ~head;
            Twenty_bucks <= head;
            state        <= PULSE;
          end else if (launch_cancel) begin
            Cancel <= 1'b1;
            state  <= PULSE;
          end else if (state == GAP) begin
            if (gap_last) state <= IDLE;
            else          gap_cnt <= gap_cnt + 4'd1;
          end
        end
        PULSE: begin
          state   <= GAP;
          gap_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COIN_CREDIT_EN
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > 9'd250) ? 8'd250 : s[7:0];
  endfunction

  // Credit follows the registered pulses, so it lands one cycle after them.
  always_ff @(posedge Clock) begin
    if (!Reset)            Credit_total <= '0;
    else if (Cancel)       Credit_total <= '0;
    else if (Ten_bucks)    Credit_total <= sat_add(Credit_total, 8'd10);
    else if (Twenty_bucks) Credit_total <= sat_add(Credit_total, 8'd20);
  end
`endif

endmodule

// File: tb/tb_vm_coin_acceptor.sv
// Directed self-checking bench for vm_coin_acceptor (default parameters).
module tb_vm_coin_acceptor;

  logic Clock = 1'b0;
  logic Reset, Coin_sense, Coin_type, Cancel_btn, Hold;
  logic Ten_bucks, Twenty_bucks, Cancel, Coin_reject, Full;
`ifdef COIN_CREDIT_EN
  logic [7:0] Credit_total;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rej_total = 0;
  int multi_total = 0;
  byte ev_kind[$];
  int  ev_cyc[$];

  vm_coin_acceptor dut (
    .Clock(Clock),
    .Reset(Reset),
    .Coin_sense(Coin_sense),
    .Coin_type(Coin_type),
    .Cancel_btn(Cancel_btn),
    .Hold(Hold),
    .Ten_bucks(Ten_bucks),
    .Twenty_bucks(Twenty_bucks),
    .Cancel(Cancel),
    .Coin_reject(Coin_reject),
    .Full(Full)
`ifdef COIN_CREDIT_EN
    , .Credit_total(Credit_total)
`endif
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // Record every emitted pulse with the cycle it was visible in.
  always @(negedge Clock) begin
    if (Ten_bucks)    begin ev_kind.push_back("T"); ev_cyc.push_back(cyc); end
    if (Twenty_bucks) begin ev_kind.push_back("W"); ev_cyc.push_back(cyc); end
    if (Cancel)       begin ev_kind.push_back("C"); ev_cyc.push_back(cyc); end
    if (Coin_reject)  rej_total <= rej_total + 1;
    if ((32'(Ten_bucks) + 32'(Twenty_bucks) + 32'(Cancel)) > 1) multi_total <= multi_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input int idx, input byte kind, input int at);
    if (idx < ev_kind.size()) begin
      chk({tag, "_kind"}, 32'(ev_kind[idx]), 32'(kind));
      chk({tag, "_cyc"}, ev_cyc[idx], at);
    end else begin
      chk({tag, "_missing"}, ev_kind.size(), idx + 1);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Clean coin: 8 cycles sensed, then 8 cycles absent so the level settles low.
  task automatic insert_coin(input logic typ);
    Coin_type  = typ;
    Coin_sense = 1'b1;
    step(8);
    Coin_sense = 1'b0;
    step(8);
  endtask

  task automatic press_cancel();
    Cancel_btn = 1'b1;
    step(8);
    Cancel_btn = 1'b0;
    step(8);
  endtask

  int base_ev, base_rej, t0, h;

  initial begin
    Reset = 1'b0; Coin_sense = 1'b0; Coin_type = 1'b0; Cancel_btn = 1'b0; Hold = 1'b0;
    step(3);
    chk("rst_ten", Ten_bucks, 0);
    chk("rst_twenty", Twenty_bucks, 0);
    chk("rst_cancel", Cancel, 0);
    chk("rst_reject", Coin_reject, 0);
    chk("rst_full", Full, 0);
    Reset = 1'b1;
    step(2);

    // Single ten coin: pulse 8 cycles after the raw rise.
    base_ev = ev_kind.size(); base_rej = rej_total;
    t0 = cyc;
    Coin_type = 1'b0; Coin_sense = 1'b1;
    step(10);
    Coin_sense = 1'b0;
    step(20);
    chk("single_count", ev_kind.size() - base_ev, 1);
    chk_ev("single", base_ev, "T", t0 + 8);
    chk("single_rej", rej_total - base_rej, 0);

    // Bounce: toggle every 2 cycles for 12 cycles.
    base_ev = ev_kind.size(); base_rej = rej_total;
    for (int i = 0; i < 6; i++) begin
      Coin_sense = ~Coin_sense;
      step(2);
    end
    Coin_sense = 1'b0;
    step(20);
    chk("bounce_count", ev_kind.size() - base_ev, 0);
    chk("bounce_rej", rej_total - base_rej, 0);
    chk("bounce_full", Full, 0);

    // Burst of 6 coins with Hold=1: T,W,W,T then two rejected.
    base_ev = ev_kind.size(); base_rej = rej_total;
    Hold = 1'b1;
    insert_coin(1'b0); insert_coin(1'b1); insert_coin(1'b1);
    chk("burst_full3", Full, 0);
    insert_coin(1'b0);
    chk("burst_full4", Full, 1);
    insert_coin(1'b0); insert_coin(1'b1);
    chk("burst_rej", rej_total - base_rej, 2);
    chk("burst_full6", Full, 1);
    chk("burst_held", ev_kind.size() - base_ev, 0);
    h = cyc;
    Hold = 1'b0;
    step(20);
    chk("burst_count", ev_kind.size() - base_ev, 4);
    chk_ev("burst0", base_ev + 0, "T", h + 1);
    chk_ev("burst1", base_ev + 1, "W", h + 4);
    chk_ev("burst2", base_ev + 2, "W", h + 7);
    chk_ev("burst3", base_ev + 3, "T", h + 10);
    chk("burst_full_end", Full, 0);

    // Cancel ordering: W,W queued, cancel, third coin rejected.
    base_ev = ev_kind.size(); base_rej = rej_total;
    Hold = 1'b1;
    insert_coin(1'b1); insert_coin(1'b1);
    press_cancel();
    insert_coin(1'b0);
    chk("cancel_rej", rej_total - base_rej, 1);
    h = cyc;
    Hold = 1'b0;
    step(20);
    chk("cancel_count", ev_kind.size() - base_ev, 3);
    chk_ev("cancel0", base_ev + 0, "W", h + 1);
    chk_ev("cancel1", base_ev + 1, "W", h + 4);
    chk_ev("cancel2", base_ev + 2, "C", h + 7);
    // Pending cleared: a new coin is accepted and emitted.
    base_ev = ev_kind.size(); base_rej = rej_total;
    t0 = cyc;
    insert_coin(1'b0);
    step(4);
    chk("after_cancel_rej", rej_total - base_rej, 0);
    chk("after_cancel_count", ev_kind.size() - base_ev, 1);
    chk_ev("after_cancel", base_ev, "T", t0 + 8);

    // Reset during GAP with 3 coins still queued.
    Hold = 1'b1;
    repeat (4) insert_coin(1'b0);
    chk("rstmid_full_before", Full, 1);
    h = cyc;
    Hold = 1'b0;
    step(2);
    Reset = 1'b0;
    step(1);
    Reset = 1'b1;
    chk("rstmid_ten", Ten_bucks, 0);
    chk("rstmid_twenty", Twenty_bucks, 0);
    chk("rstmid_cancel", Cancel, 0);
    chk("rstmid_reject", Coin_reject, 0);
    chk("rstmid_full", Full, 0);
    base_ev = ev_kind.size(); base_rej = rej_total;
    step(30);
    chk("rstmid_lost", ev_kind.size() - base_ev, 0);
    chk("rstmid_rej", rej_total - base_rej, 0);

`ifdef COIN_CREDIT_EN
    chk("credit_rst", Credit_total, 0);
    insert_coin(1'b0);
    chk("credit_10", Credit_total, 10);
    insert_coin(1'b1);
    chk("credit_30", Credit_total, 30);
    insert_coin(1'b1);
    chk("credit_50", Credit_total, 50);
    repeat (12) insert_coin(1'b1);
    chk("credit_sat", Credit_total, 250);
    press_cancel();
    step(4);
    chk("credit_clear", Credit_total, 0);
`endif

    chk("onehot", multi_total, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
